// File: rtl/snippet_resp_checker_if.sv
// Observed/expected vector stream plus run control and result bus for the response checker.
// The master drives stimulus and control; the slave is the checker and returns registered results.
interface snippet_resp_checker_if #(
    parameter int CNT_W = 8
);
    logic             start;
    logic [CNT_W-1:0] num_vec;
    logic             obs_valid;
    logic             obs_f;
    logic             obs_g;
    logic             exp_f;
    logic             exp_g;
    logic             busy;
    logic             done;
    logic             pass;
    logic [CNT_W-1:0] err_count;
    logic             fail_seen;
    logic [CNT_W-1:0] first_fail_idx;
    logic [CNT_W-1:0] vec_idx;

    modport master (
        output start, num_vec, obs_valid, obs_f, obs_g, exp_f, exp_g,
        input  busy, done, pass, err_count, fail_seen, first_fail_idx, vec_idx
    );

    modport slave (
        input  start, num_vec, obs_valid, obs_f, obs_g, exp_f, exp_g,
        output busy, done, pass, err_count, fail_seen, first_fail_idx, vec_idx
    );
endinterface

// File: rtl/snippet_resp_checker.sv
// Compares observed f/g against expected per vector, counts mismatches, reports pass/fail per run.
// Latency: results update one cycle after a sampled vector; done pulses the cycle after the last one.
// Backpressure: none; accepts one vector per clock and waits indefinitely between vectors.
module snippet_resp_checker #(
    parameter int CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    snippet_resp_checker_if.slave  bus
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] num_q, num_d;
    logic [CNT_W-1:0] err_q, err_d;
    logic [CNT_W-1:0] first_q, first_d;
    logic [CNT_W-1:0] vidx_q, vidx_d;
    logic             fail_q, fail_d;
    logic             pass_q, pass_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic mismatch;
    logic last_vec;

    assign mismatch = (bus.obs_f ^ bus.exp_f) | (bus.obs_g ^ bus.exp_g);
    assign last_vec = (vidx_q == (num_q - CNT_ONE));

    always_comb begin
        state_d = state_q;
        num_d   = num_q;
        err_d   = err_q;
        first_d = first_q;
        vidx_d  = vidx_q;
        fail_d  = fail_q;
        pass_d  = pass_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    num_d   = bus.num_vec;
                    err_d   = '0;
                    first_d = '0;
                    vidx_d  = '0;
                    fail_d  = 1'b0;
                    pass_d  = 1'b0;
                    // An empty run finishes immediately and trivially passes.
                    if (bus.num_vec == '0) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        pass_d  = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                        busy_d  = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                busy_d = 1'b1;
                if (bus.obs_valid) begin
                    if (mismatch) begin
                        if (err_q != CNT_MAX) begin
                            err_d = err_q + CNT_ONE;
                        end
                        fail_d = 1'b1;
                        if (!fail_q) begin
                            first_d = vidx_q;
                        end
                    end
                    vidx_d = vidx_q + CNT_ONE;
                    // Pass is resolved on entry to DONE so it is valid alongside done.
                    if (last_vec) begin
                        state_d = ST_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = ~(fail_q | mismatch);
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            num_q   <= '0;
            err_q   <= '0;
            first_q <= '0;
            vidx_q  <= '0;
            fail_q  <= 1'b0;
            pass_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            num_q   <= num_d;
            err_q   <= err_d;
            first_q <= first_d;
            vidx_q  <= vidx_d;
            fail_q  <= fail_d;
            pass_q  <= pass_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy           = busy_q;
    assign bus.done           = done_q;
    assign bus.pass           = pass_q;
    assign bus.err_count      = err_q;
    assign bus.fail_seen      = fail_q;
    assign bus.first_fail_idx = first_q;
    assign bus.vec_idx        = vidx_q;
endmodule

// File: tb/tb_snippet_resp_checker.sv
// Directed bench for snippet_resp_checker: an 8-bit instance for the main runs, a 2-bit one for narrow counters.
module tb_snippet_resp_checker;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    snippet_resp_checker_if #(.CNT_W(8)) bus8 ();
    snippet_resp_checker_if #(.CNT_W(2)) bus2 ();

    snippet_resp_checker #(.CNT_W(8)) u_dut8 (.clk(clk), .rst(rst), .bus(bus8));
    snippet_resp_checker #(.CNT_W(2)) u_dut2 (.clk(clk), .rst(rst), .bus(bus2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; outputs are sampled and inputs changed here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic vec8(input logic of, input logic og, input logic ef, input logic eg);
        bus8.obs_valid = 1'b1;
        bus8.obs_f = of; bus8.obs_g = og;
        bus8.exp_f = ef; bus8.exp_g = eg;
        tick();
        bus8.obs_valid = 1'b0;
    endtask

    task automatic start8(input logic [7:0] n);
        bus8.start = 1'b1;
        bus8.num_vec = n;
        tick();
        bus8.start = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        bus8.start = 1'b0; bus8.num_vec = '0; bus8.obs_valid = 1'b0;
        bus8.obs_f = 1'b0; bus8.obs_g = 1'b0; bus8.exp_f = 1'b0; bus8.exp_g = 1'b0;
        bus2.start = 1'b0; bus2.num_vec = '0; bus2.obs_valid = 1'b0;
        bus2.obs_f = 1'b0; bus2.obs_g = 1'b0; bus2.exp_f = 1'b0; bus2.exp_g = 1'b0;

        // Reset state
        tick();
        tick();
        rst = 1'b0;
        check("rst_busy",  32'(bus8.busy), 32'd0);
        check("rst_done",  32'(bus8.done), 32'd0);
        check("rst_pass",  32'(bus8.pass), 32'd0);
        check("rst_err",   32'(bus8.err_count), 32'd0);
        check("rst_fail",  32'(bus8.fail_seen), 32'd0);
        check("rst_first", 32'(bus8.first_fail_idx), 32'd0);
        check("rst_vidx",  32'(bus8.vec_idx), 32'd0);

        // All-match run, back-to-back vectors
        start8(8'd3);
        check("m_busy", 32'(bus8.busy), 32'd1);
        bus8.obs_valid = 1'b1;
        bus8.obs_f = 1'b0; bus8.obs_g = 1'b1; bus8.exp_f = 1'b0; bus8.exp_g = 1'b1;
        tick();
        check("m_vidx1", 32'(bus8.vec_idx), 32'd1);
        check("m_nodone", 32'(bus8.done), 32'd0);
        tick();
        bus8.obs_f = 1'b1; bus8.exp_f = 1'b1;
        tick();
        bus8.obs_valid = 1'b0;
        check("m_done", 32'(bus8.done), 32'd1);
        check("m_busy0", 32'(bus8.busy), 32'd0);
        check("m_pass", 32'(bus8.pass), 32'd1);
        check("m_err", 32'(bus8.err_count), 32'd0);
        check("m_fail", 32'(bus8.fail_seen), 32'd0);
        check("m_vidx", 32'(bus8.vec_idx), 32'd3);
        tick();
        check("m_done_pulse", 32'(bus8.done), 32'd0);
        check("m_pass_hold", 32'(bus8.pass), 32'd1);

        // Single mismatch on vector 1
        start8(8'd3);
        check("s_pass_clr", 32'(bus8.pass), 32'd0);
        vec8(1'b1, 1'b0, 1'b1, 1'b0);
        vec8(1'b0, 1'b1, 1'b1, 1'b1);
        vec8(1'b1, 1'b1, 1'b1, 1'b1);
        check("s_done", 32'(bus8.done), 32'd1);
        check("s_err", 32'(bus8.err_count), 32'd1);
        check("s_fail", 32'(bus8.fail_seen), 32'd1);
        check("s_first", 32'(bus8.first_fail_idx), 32'd1);
        check("s_pass", 32'(bus8.pass), 32'd0);
        tick();

        // Gapped valid with a start pulse mid-run that must be ignored
        start8(8'd2);
        tick();
        vec8(1'b0, 1'b0, 1'b0, 1'b0);
        check("g_vidx1", 32'(bus8.vec_idx), 32'd1);
        tick();
        start8(8'd7);
        check("g_busy_after_start", 32'(bus8.busy), 32'd1);
        check("g_vidx_kept", 32'(bus8.vec_idx), 32'd1);
        tick();
        check("g_busy_wait", 32'(bus8.busy), 32'd1);
        check("g_nodone", 32'(bus8.done), 32'd0);
        vec8(1'b1, 1'b0, 1'b1, 1'b0);
        check("g_done", 32'(bus8.done), 32'd1);
        check("g_vidx", 32'(bus8.vec_idx), 32'd2);
        check("g_pass", 32'(bus8.pass), 32'd1);
        tick();
        check("g_idle_busy", 32'(bus8.busy), 32'd0);

        // Zero-length run
        start8(8'd0);
        check("z_done", 32'(bus8.done), 32'd1);
        check("z_pass", 32'(bus8.pass), 32'd1);
        check("z_busy", 32'(bus8.busy), 32'd0);
        check("z_vidx", 32'(bus8.vec_idx), 32'd0);
        tick();
        check("z_done_pulse", 32'(bus8.done), 32'd0);
        check("z_busy_idle", 32'(bus8.busy), 32'd0);

        // Narrow counters: longest run, every vector mismatching, then a stray valid
        bus2.start = 1'b1;
        bus2.num_vec = 2'd3;
        tick();
        bus2.start = 1'b0;
        bus2.obs_valid = 1'b1;
        bus2.obs_f = 1'b0; bus2.obs_g = 1'b0; bus2.exp_f = 1'b1; bus2.exp_g = 1'b0;
        tick();
        bus2.exp_g = 1'b1;
        tick();
        tick();
        check("n_done", 32'(bus2.done), 32'd1);
        check("n_err", 32'(bus2.err_count), 32'd3);
        check("n_first", 32'(bus2.first_fail_idx), 32'd0);
        check("n_pass", 32'(bus2.pass), 32'd0);
        check("n_vidx", 32'(bus2.vec_idx), 32'd3);
        tick();
        check("n_extra_err", 32'(bus2.err_count), 32'd3);
        check("n_extra_vidx", 32'(bus2.vec_idx), 32'd3);
        tick();
        bus2.obs_valid = 1'b0;
        check("n_extra_err2", 32'(bus2.err_count), 32'd3);
        check("n_extra_busy", 32'(bus2.busy), 32'd0);

        // Reset mid-run aborts without a done pulse
        start8(8'd5);
        vec8(1'b1, 1'b0, 1'b0, 1'b0);
        vec8(1'b1, 1'b1, 1'b1, 1'b0);
        check("r_err_pre", 32'(bus8.err_count), 32'd2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("r_busy", 32'(bus8.busy), 32'd0);
        check("r_done", 32'(bus8.done), 32'd0);
        check("r_err", 32'(bus8.err_count), 32'd0);
        check("r_fail", 32'(bus8.fail_seen), 32'd0);
        check("r_first", 32'(bus8.first_fail_idx), 32'd0);
        check("r_vidx", 32'(bus8.vec_idx), 32'd0);
        tick();
        check("r_done_after", 32'(bus8.done), 32'd0);
        start8(8'd1);
        check("r2_busy", 32'(bus8.busy), 32'd1);
        vec8(1'b0, 1'b1, 1'b0, 1'b1);
        check("r2_done", 32'(bus8.done), 32'd1);
        check("r2_pass", 32'(bus8.pass), 32'd1);
        check("r2_vidx", 32'(bus8.vec_idx), 32'd1);
        check("r2_err", 32'(bus8.err_count), 32'd0);
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
